// File: rtl/cnn_layer_accel_input_sequencer.sv
// Input sequencer for cnn_layer_accel_octo: pulses new_map, streams the generated
// per-column sequence table, then forwards a fixed number of upstream pixels.
module cnn_layer_accel_input_sequencer #(
   parameter int C_PIXEL_WIDTH    = 16,
   parameter int C_SEQ_DATA_WIDTH = 13,
   parameter int C_CNT_WIDTH      = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic [8:0]               cfg_num_out_cols,
   input  logic [C_CNT_WIDTH-1:0]   cfg_num_pixels,
   output logic                     busy,
   output logic                     done,
   output logic                     new_map,
   input  logic [C_PIXEL_WIDTH-1:0] pix_in,
   input  logic                     pix_in_valid,
   output logic                     pix_in_rdy,
   output logic [C_PIXEL_WIDTH-1:0] datain,
   output logic                     datain_valid,
   output logic                     seq_datain_tag,
   input  logic                     seq_datain_rdy,
   output logic                     pixel_datain_tag,
   input  logic                     pixel_datain_rdy
);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_NEWMAP = 3'd1;
   localparam logic [2:0] ST_GAP    = 3'd2;
   localparam logic [2:0] ST_SEQ    = 3'd3;
   localparam logic [2:0] ST_PIX    = 3'd4;
   localparam logic [2:0] ST_DONE   = 3'd5;

   logic [2:0]               r_state;
   logic [8:0]               r_last_g;
   logic [9:0]               r_g;
   logic [2:0]               r_w;
   logic [C_CNT_WIDTH-1:0]   r_rem_accept;
   logic [C_PIXEL_WIDTH-1:0] r_pix_data;
   logic                     r_pix_valid;

   logic                        w_rm;
   logic                        w_rst;
   logic                        w_p;
   logic [9:0]                  w_seq_field;
   logic [C_SEQ_DATA_WIDTH-1:0] w_seq_word;
   logic                        w_seq_last;
   logic                        w_pix_accept;
   logic                        w_pix_xfer;

   // Word layout {RM, RST, P, SEQ[9:0]}; SEQ math is 10-bit and wraps naturally.
   // NOTE: every signal gets a default at the top of always_comb so no path can infer a latch.
   always_comb begin
      w_rm        = 1'b0;
      w_rst       = 1'b0;
      w_p         = 1'b0;
      w_seq_field = r_g;
      case (r_w)
         3'd0: begin
            w_rst = 1'b1;
            w_p   = ~r_g[0];
         end
         3'd1: begin
            w_p         = r_g[0];
            w_seq_field = {r_g[9:1], 1'b0} + 10'd2;
         end
         3'd2:    w_seq_field = r_g + 10'd512;
         3'd3:    w_seq_field = r_g + 10'd513;
         default: begin
            w_rm        = 1'b1;
            w_seq_field = r_g + 10'd514;
         end
      endcase
   end

   assign w_seq_word   = {w_rm, w_rst, w_p, w_seq_field};
   assign w_seq_last   = (r_g == {1'b0, r_last_g}) && (r_w == 3'd4);
   assign w_pix_xfer   = r_pix_valid && pixel_datain_rdy;
   assign pix_in_rdy   = (r_state == ST_PIX) && (r_rem_accept != '0) &&
                         (!r_pix_valid || pixel_datain_rdy);
   assign w_pix_accept = pix_in_valid && pix_in_rdy;

   assign busy             = (r_state != ST_IDLE);
   assign done             = (r_state == ST_DONE);
   assign new_map          = (r_state == ST_NEWMAP);
   assign seq_datain_tag   = (r_state == ST_SEQ);
   assign pixel_datain_tag = (r_state == ST_PIX);
   assign datain_valid     = (r_state == ST_SEQ) || ((r_state == ST_PIX) && r_pix_valid);
   assign datain           = (r_state == ST_SEQ) ? C_PIXEL_WIDTH'(w_seq_word) :
                             (r_state == ST_PIX) ? r_pix_data : '0;

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         r_last_g     <= '0;
         r_g          <= '0;
         r_w          <= '0;
         r_rem_accept <= '0;
         r_pix_data   <= '0;
         r_pix_valid  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_state      <= ST_NEWMAP;
                  r_last_g     <= cfg_num_out_cols;
                  r_rem_accept <= cfg_num_pixels;
                  r_g          <= '0;
                  r_w          <= '0;
                  r_pix_valid  <= 1'b0;
               end
            end
            ST_NEWMAP: r_state <= ST_GAP;
            ST_GAP:    r_state <= ST_SEQ;
            ST_SEQ: begin
               if (seq_datain_rdy) begin
                  if (w_seq_last) begin
                     r_state <= ST_PIX;
                  end else if (r_w == 3'd4) begin
                     r_w <= '0;
                     r_g <= r_g + 10'd1;
                  end else begin
                     r_w <= r_w + 3'd1;
                  end
               end
            end
            ST_PIX: begin
               if (w_pix_accept) begin
                  r_pix_data   <= pix_in;
                  r_pix_valid  <= 1'b1;
                  r_rem_accept <= r_rem_accept - 1'b1;
               end else if (w_pix_xfer) begin
                  r_pix_valid <= 1'b0;
               end
               // With nothing left to accept, the register holds the final pixel.
               if (w_pix_xfer && (r_rem_accept == '0)) begin
                  r_state <= ST_DONE;
               end
            end
            ST_DONE: r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cnn_layer_accel_input_sequencer.sv
// Scoreboard bench: expected words/pixels queued at start, monitor pops on every
// downstream transfer; randomized handshakes, mid-run resets and stray starts.
module tb_cnn_layer_accel_input_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [8:0]  cfg_num_out_cols = '0;
   logic [15:0] cfg_num_pixels = '0;
   logic        busy, done, new_map;
   logic [15:0] pix_in = '0;
   logic        pix_in_valid = 1'b0;
   logic        pix_in_rdy;
   logic [15:0] datain;
   logic        datain_valid, seq_datain_tag, pixel_datain_tag;
   logic        seq_datain_rdy = 1'b0;
   logic        pixel_datain_rdy = 1'b0;

   cnn_layer_accel_input_sequencer dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .start            (start),
      .cfg_num_out_cols (cfg_num_out_cols),
      .cfg_num_pixels   (cfg_num_pixels),
      .busy             (busy),
      .done             (done),
      .new_map          (new_map),
      .pix_in           (pix_in),
      .pix_in_valid     (pix_in_valid),
      .pix_in_rdy       (pix_in_rdy),
      .datain           (datain),
      .datain_valid     (datain_valid),
      .seq_datain_tag   (seq_datain_tag),
      .seq_datain_rdy   (seq_datain_rdy),
      .pixel_datain_tag (pixel_datain_tag),
      .pixel_datain_rdy (pixel_datain_rdy)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   logic [16:0] exp_q[$];   // {is_seq_word, data}
   logic [15:0] src[$];
   int cur_npix = 0;
   int n_seq_xfer = 0, n_pix_xfer = 0, n_seq_cyc = 0, n_acc = 0;
   int n_newmap = 0, n_done = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference table entry k: group g = k/5, word index w = k%5.
   function automatic logic [15:0] seq_word(input int k);
      int g, w, s, rm, rs, p, v;
      g = k / 5; w = k % 5; rm = 0; rs = 0; p = 0; s = 0;
      case (w)
         0: begin rs = 1; p = (g % 2 == 0) ? 1 : 0; s = g; end
         1: begin p = g % 2; s = (g - (g % 2)) + 2; end
         2: s = 512 + g;
         3: s = 513 + g;
         default: begin rm = 1; s = 514 + g; end
      endcase
      v = rm * 4096 + rs * 2048 + p * 1024 + (s % 1024);
      return v[15:0];
   endfunction

   function automatic logic [31:0] outs();
      return {9'd0, busy, done, new_map, pix_in_rdy, datain_valid,
              seq_datain_tag, pixel_datain_tag, datain};
   endfunction

   // Monitor: pops the scoreboard on each transfer and checks hold-stability.
   logic        prev_hold = 1'b0;
   logic [15:0] prev_data = '0;
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_hold = 1'b0;
      end else begin
         logic xfer;
         logic [16:0] e;
         if (new_map) n_newmap++;
         if (done) n_done++;
         if (seq_datain_tag) n_seq_cyc++;
         if (prev_hold) begin
            check("hold_valid", {31'd0, datain_valid}, 32'd1);
            check("hold_data", {16'd0, datain}, {16'd0, prev_data});
         end
         if (datain_valid)
            check("one_tag", {31'd0, seq_datain_tag ^ pixel_datain_tag}, 32'd1);
         xfer = datain_valid && (seq_datain_tag ? seq_datain_rdy
                                                : (pixel_datain_tag && pixel_datain_rdy));
         if (xfer) begin
            if (exp_q.size() == 0) begin
               check("extra_xfer", {15'd0, seq_datain_tag, datain}, 32'h1ffff);
            end else begin
               e = exp_q.pop_front();
               check("xfer", {15'd0, seq_datain_tag, datain}, {15'd0, e});
            end
            if (seq_datain_tag) n_seq_xfer++; else n_pix_xfer++;
         end
         if (pixel_datain_tag && n_acc >= cur_npix)
            check("rdy_after_last", {31'd0, pix_in_rdy}, 32'd0);
         if (pix_in_valid && pix_in_rdy) n_acc++;
         prev_hold = datain_valid && !xfer;
         prev_data = datain;
      end
   end

   task automatic do_reset_release();
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic run(input int cols, input int npix, input bit bp, input bit inj,
                      input int rst_word, input int rst_pix);
      int groups, idx;
      bit accept_prev, pv, got_done, aborted;
      logic [31:0] r;
      groups = cols + 1;
      exp_q.delete(); src.delete();
      for (int k = 0; k < groups * 5; k++) exp_q.push_back({1'b1, seq_word(k)});
      for (int i = 0; i < npix; i++) begin
         r = $urandom;
         src.push_back(r[15:0]);
         exp_q.push_back({1'b0, r[15:0]});
      end
      cur_npix = npix;
      n_seq_xfer = 0; n_pix_xfer = 0; n_seq_cyc = 0; n_acc = 0; n_newmap = 0; n_done = 0;

      @(posedge clk); #1;
      start = 1'b1; cfg_num_out_cols = cols[8:0]; cfg_num_pixels = npix[15:0];
      seq_datain_rdy = 1'b1; pixel_datain_rdy = 1'b0; pix_in_valid = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      r = $urandom;
      cfg_num_out_cols = r[8:0]; cfg_num_pixels = r[31:16];
      @(negedge clk);
      check("newmap_cycle", {30'd0, busy, new_map}, 32'd3);
      @(negedge clk);
      check("gap_cycle", {28'd0, busy, new_map, datain_valid, seq_datain_tag}, 32'd8);
      @(negedge clk);
      check("word0", {14'd0, datain_valid, seq_datain_tag, datain}, 32'h30c00);

      idx = 0; accept_prev = 0; pv = 0; got_done = 0; aborted = 0;
      for (int cyc = 0; cyc < 20000; cyc++) begin
         @(posedge clk); #1;
         if ((rst_word >= 0 && n_seq_xfer >= rst_word) ||
             (rst_pix >= 0 && n_pix_xfer >= rst_pix)) begin
            rst_n = 1'b0; start = 1'b0;
            #1;
            check("async_reset_outs", outs(), 32'd0);
            aborted = 1;
            break;
         end
         if (accept_prev) begin idx++; pv = 0; end
         if (!pv) pv = (idx < npix) && ($urandom_range(9) < 7);
         pix_in_valid     = pv;
         pix_in           = (idx < npix) ? src[idx] : 16'h0;
         seq_datain_rdy   = bp ? ($urandom_range(9) >= 3) : 1'b1;
         pixel_datain_rdy = ($urandom_range(9) < 7);
         start            = inj && ($urandom_range(9) == 0);
         @(negedge clk);
         accept_prev = pix_in_valid && pix_in_rdy;
         if (done) begin got_done = 1; start = 1'b0; break; end
      end
      start = 1'b0;

      if (aborted) begin
         exp_q.delete();
         repeat (2) @(negedge clk);
         check("reset_held_outs", outs(), 32'd0);
         check("no_done_on_reset", n_done, 32'd0);
         do_reset_release();
      end else if (!got_done) begin
         check("done_timeout", 32'd0, 32'd1);
      end else begin
         check("queue_drained", exp_q.size(), 32'd0);
         check("seq_words", n_seq_xfer, groups * 5);
         check("pix_words", n_pix_xfer, npix);
         if (!bp) check("seq_cycles_no_gap", n_seq_cyc, groups * 5);
         @(negedge clk);
         check("after_done", {30'd0, busy, done}, 32'd0);
         check("done_pulses", n_done, 32'd1);
         check("newmap_pulses", n_newmap, 32'd1);
      end
      pix_in_valid = 1'b0;
   endtask

   initial begin
      #3;
      check("reset_outs", outs(), 32'd0);
      @(posedge clk); #1 rst_n = 1'b1;

      run(7, 20, 0, 0, -1, -1);     // 40 words back-to-back
      run(7, 30, 1, 0, -1, -1);     // seq backpressure
      run(0, 5, 0, 0, -1, -1);      // single group
      run(3, 100, 1, 0, -1, -1);    // 100 pixels, random both sides
      run(7, 40, 1, 1, -1, -1);     // stray starts during SEQ/PIX
      run(7, 100, 1, 0, 17, -1);    // reset during word 17
      run(7, 20, 0, 0, -1, -1);     // restart from word 0
      run(7, 100, 1, 0, -1, 43);    // reset during pixel 43
      run(2, 100, 1, 1, -1, -1);
      run(511, 8, 0, 0, -1, -1);    // SEQ wrap mod 1024

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/cnn_layer_accel_input_sequencer.md
# cnn_layer_accel_input_sequencer

Upstream feeder for `cnn_layer_accel_octo`. On `start` it pulses `new_map` and generates the per-output-column sequence table in hardware: `(cfg_num_out_cols+1)*5` words on the octo's `datain` bus with `seq_datain_tag`. It then forwards `cfg_num_pixels` input-map pixels from an upstream valid/ready stream with `pixel_datain_tag`. It replaces host-built sequence tables and directly drives the octo's load interface.

## Interface
- `C_PIXEL_WIDTH`, 16, width of `datain`/`pix_in`; must be ≥ `C_SEQ_DATA_WIDTH`.
- `C_SEQ_DATA_WIDTH`, 13, sequence word width: {RM[12], RST[11], P[10], SEQ[9:0]}.
- `C_CNT_WIDTH`, 16, pixel counter width.

Ports:
- `clk` in 1: single clock, all logic on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle request; honoured only in IDLE.
- `cfg_num_out_cols` in 9: output columns minus 1; G = `cfg_num_out_cols`+1 groups. Sampled on start.
- `cfg_num_pixels` in `C_CNT_WIDTH`: pixels to forward (rows*cols), ≥1. Sampled on start.
- `busy` out 1: high from accepted start until DONE exits.
- `done` out 1: one-cycle pulse after the last pixel transfer.
- `new_map` out 1: one-cycle pulse to the octo.
- `pix_in` in `C_PIXEL_WIDTH`: upstream pixel data.
- `pix_in_valid` in 1: upstream pixel valid.
- `pix_in_rdy` out 1: upstream pixel ready.
- `datain` out `C_PIXEL_WIDTH`: to octo; sequence words are zero-extended.
- `datain_valid` out 1: to octo.
- `seq_datain_tag` out 1: to octo.
- `seq_datain_rdy` in 1: from octo.
- `pixel_datain_tag` out 1: to octo.
- `pixel_datain_rdy` in 1: from octo.

## Operation
- FSM states: IDLE → NEWMAP (1 cycle, `new_map`=1) → GAP (1 cycle, all outputs idle) → SEQ → PIX → DONE (1 cycle, `done`=1) → IDLE.
- Sequence word k, with group g=k/5 and index w=k%5:
  - w0 = {0, 1, ~g[0], g}.
  - w1 = {0, 0, g[0], (g & ~1)+2}.
  - w2 = {0, 0, 0, 512+g}.
  - w3 = {0, 0, 0, 513+g}.
  - w4 = {1, 0, 0, 514+g}.
- All SEQ arithmetic is 10-bit and wraps mod 1024. Implement with incremental registers (g, w counters), not a multiplier.
- SEQ state:
  - `seq_datain_tag`=1 throughout; `datain_valid`=1; `datain` holds word k.
  - A transfer occurs on any edge with `datain_valid`&&`seq_datain_rdy`; the word then advances to k+1.
  - After word 5G−1 transfers: `datain_valid` drops, the tag drops, and the FSM goes to PIX. The next word is never presented.
- PIX state:
  - `pixel_datain_tag`=1 throughout.
  - One-entry output register: `pix_in_rdy` = (remaining_accept>0) && (!`datain_valid` || `pixel_datain_rdy`).
  - Upstream accept on `pix_in_valid`&&`pix_in_rdy` loads `datain`, sets `datain_valid`, and decrements remaining_accept.
  - A downstream transfer without a simultaneous accept clears `datain_valid`.
  - Last downstream transfer: go to DONE; tag and valid drop.
- While valid and not transferred, `datain` is held stable.
- `start` outside IDLE is ignored. Config changes after start have no effect.

## Timing
- Reset (async assert, sync-safe release): FSM IDLE, all outputs 0, counters 0.
- Start accepted at edge N: `busy`=1 and `new_map`=1 in cycle N+1; GAP in N+2; word 0 valid from N+3.
- SEQ throughput is 1 word/cycle with `seq_datain_rdy` held high, giving 5G cycles for the table.
- PIX throughput is 1 pixel/cycle, with 1-cycle latency from upstream accept to `datain_valid`.
- Simultaneous accept and downstream transfer in the same cycle keeps valid high and loads new data (no bubble).
- `done` asserts the cycle after the final pixel transfer edge; `busy` falls with the return to IDLE one cycle later.
- `rst_n` low mid-operation: immediate return to IDLE. Tags, valid and `done` clear; no `done` pulse. The next start restarts from word 0.

## Test plan
- cfg_num_out_cols=7, rdy always high → 40 words, no gaps:
  - word0=0xC00, word1=0x002, word4=0x1202, word5=0x801, word6=0x402.
  - word10=0xC02, word11=0x004, word39=0x1209.
  - Then the tag drops.
- Random `seq_datain_rdy` backpressure (30% low) → identical 40-word sequence; `datain` is stable while rdy is low; no word is skipped or duplicated.
- cfg_num_out_cols=0 → exactly 5 words (0xC00, 0x002, 0x200, 0x201, 0x1202), then PIX.
- cfg_num_pixels=100 with random valid/rdy on both sides → 100 pixels in order, then a one-cycle `done`; `pix_in_rdy` stays 0 after the 100th accept.
- `rst_n` pulsed low during word 17 and during pixel 43 → outputs 0 asynchronously, no `done`; the following start reproduces the full sequence from word 0.
- `start` pulsed during SEQ and PIX → ignored; exactly one `new_map` pulse per accepted start.
